prog_sequencer: RTL and testbench

- Control-side counterpart of the program counter. Drives the PC's inputs (op, z, lt, bamt, pc_reset) and consumes the instruction fetched at that PC.
- Sequences the three benchmark programs in order: PRODUCT, STRING MATCH, CLOSEST PAIR. For each one it issues one pc_reset pulse, decodes control-flow ops and holds the compare flags.
- Detects HALT, or a watchdog timeout, and reports completion through a start/done four-phase handshake with the testbench/top.

---
 rtl/prog_sequencer_pkg.sv | 31 +++
 rtl/prog_sequencer_if.sv | 27 ++
 rtl/prog_sequencer_branch_lut.sv | 13 +
 rtl/prog_sequencer.sv | 108 ++++++++++
 tb/tb_prog_sequencer.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and branch-offset table for the program sequencer.
package prog_sequencer_pkg;

  localparam int OP_W         = 5;
  localparam int INSTR_W      = 9;
  localparam int BAMT_W       = 15;
  localparam int BLUT_ENTRIES = 16;

  localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OP_W-1:0] OP_CMP  = 5'h08;
  localparam logic [OP_W-1:0] OP_BA   = 5'h10;
  localparam logic [OP_W-1:0] OP_BL   = 5'h11;
  localparam logic [OP_W-1:0] OP_BG   = 5'h12;
  localparam logic [OP_W-1:0] OP_BE   = 5'h13;
  localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic [1:0] {IDLE, PULSE, RUN, DONE} state_t;

  // Backward offsets are 15-bit two's complement; the PC keeps only its low 8 bits.
  localparam logic [BAMT_W-1:0] BLUT [0:BLUT_ENTRIES-1] = '{
    15'h0001, 15'h0002, 15'h7FFD, 15'h0004,
    15'h7FFE, 15'h0008, 15'h7FF8, 15'h0010,
    15'h7FF0, 15'h0003, 15'h7FFF, 15'h0005,
    15'h7FFB, 15'h0006, 15'h7FFA, 15'h0020
  };

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BA) || (op == OP_BL) || (op == OP_BG) || (op == OP_BE);
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// PC-side control bus plus the start/done handshake of the program sequencer.
interface prog_sequencer_if;
  import prog_sequencer_pkg::*;

  logic                 start;
  logic [INSTR_W-1:0]   instr;
  logic                 alu_z;
  logic                 alu_lt;
  logic [OP_W-1:0]      op;
  logic                 z;
  logic                 lt;
  logic [BAMT_W-1:0]    bamt;
  logic                 pc_reset;
  logic                 done;
  logic                 timeout;
  logic [1:0]           prog_idx;

  modport master (
    input  start, instr, alu_z, alu_lt,
    output op, z, lt, bamt, pc_reset, done, timeout, prog_idx
  );

  modport slave (
    output start, instr, alu_z, alu_lt,
    input  op, z, lt, bamt, pc_reset, done, timeout, prog_idx
  );
endinterface

// File: rtl/prog_sequencer_branch_lut.sv
// Combinational branch-offset table: 4-bit instruction field to 15-bit PC offset.
module branch_lut
  import prog_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [$clog2(DEPTH)-1:0] idx,
  output logic [BAMT_W-1:0]        offset
);

  assign offset = BLUT[idx];

endmodule

// File: rtl/prog_sequencer.sv
// Runs the benchmark programs in order: one pc_reset pulse per program, op/flag
// control during RUN, HALT/watchdog completion reported over a start/done handshake.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int NUM_PROGS  = 3,
  parameter int MAX_CYCLES = 4096,
  parameter int BLUT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  prog_sequencer_if.master  bus
);

  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  state_t            state_reg, state_next;
  logic              z_reg, lt_reg, timeout_reg;
  logic [1:0]        idx_reg;
  logic [CW-1:0]     cnt_reg;
  logic [OP_W-1:0]   run_op;
  logic [BAMT_W-1:0] lut_offset;
  logic              halt, limit, all_done;

  assign run_op   = bus.instr[8:4];
  assign halt     = (run_op == OP_HALT);
  assign limit    = (cnt_reg == CW'(MAX_CYCLES - 1));
  assign all_done = (idx_reg == 2'(NUM_PROGS));

  branch_lut #(.DEPTH(BLUT_DEPTH)) u_branch_lut (
    .idx    (bus.instr[3:0]),
    .offset (lut_offset)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start && !all_done) state_next = PULSE;
      PULSE:   state_next = RUN;
      RUN:     if (halt || limit) state_next = DONE;
      DONE:    if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.op       = OP_NOP;
    bus.bamt     = '0;
    bus.pc_reset = 1'b0;
    bus.done     = 1'b0;
    bus.timeout  = 1'b0;
    case (state_reg)
      PULSE: bus.pc_reset = 1'b1;
      RUN: begin
        bus.op = run_op;
        if (is_branch(run_op)) bus.bamt = lut_offset;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.timeout = timeout_reg;
      end
      default: ;
    endcase
  end

  assign bus.z        = z_reg;
  assign bus.lt       = lt_reg;
  assign bus.prog_idx = idx_reg;

  // Flags, watchdog and timeout cause are reset on the way into PULSE so a
  // new program never sees the previous program's state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_reg       <= 1'b0;
      lt_reg      <= 1'b0;
      timeout_reg <= 1'b0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (state_next == PULSE) begin
          z_reg       <= 1'b0;
          lt_reg      <= 1'b0;
          timeout_reg <= 1'b0;
          cnt_reg     <= '0;
        end
        RUN: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (run_op == OP_CMP) begin
            z_reg  <= bus.alu_z;
            lt_reg <= bus.alu_lt;
          end
          if (state_next == DONE) begin
            timeout_reg <= !halt;
            if (!all_done) idx_reg <= idx_reg + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench: stimulus queues the expected outputs per cycle, a negedge monitor compares.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  typedef struct packed {
    logic [4:0]  op;
    logic        z;
    logic        lt;
    logic [14:0] bamt;
    logic        pc_reset;
    logic        done;
    logic        timeout;
    logic [1:0]  prog_idx;
  } exp_t;

  logic clk;
  logic reset_n;
  prog_sequencer_if bus();

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    passes;

  prog_sequencer #(.NUM_PROGS(3), .MAX_CYCLES(8), .BLUT_DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{bus.op, bus.z, bus.lt, bus.bamt, bus.pc_reset, bus.done, bus.timeout, bus.prog_idx};
      checks++;
      if (a === e) begin
        passes++;
        $display("ok   %-12s op=%h z=%b lt=%b bamt=%h pcr=%b done=%b to=%b idx=%0d",
                 nm, a.op, a.z, a.lt, a.bamt, a.pc_reset, a.done, a.timeout, a.prog_idx);
      end else begin
        $display("FAIL %-12s got op=%h z=%b lt=%b bamt=%h pcr=%b done=%b to=%b idx=%0d, expected op=%h z=%b lt=%b bamt=%h pcr=%b done=%b to=%b idx=%0d",
                 nm, a.op, a.z, a.lt, a.bamt, a.pc_reset, a.done, a.timeout, a.prog_idx,
                 e.op, e.z, e.lt, e.bamt, e.pc_reset, e.done, e.timeout, e.prog_idx);
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic st,
                      input logic [8:0] ins, input logic az, input logic al,
                      input logic [4:0] eop, input logic ez, input logic el,
                      input logic [14:0] eb, input logic epr, input logic edn,
                      input logic eto, input logic [1:0] eidx);
    reset_n    = rn;
    bus.start  = st;
    bus.instr  = ins;
    bus.alu_z  = az;
    bus.alu_lt = al;
    exp_q.push_back('{eop, ez, el, eb, epr, edn, eto, eidx});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.instr  = '0;
    bus.alu_z  = 1'b0;
    bus.alu_lt = 1'b0;
    @(posedge clk);
    #1;

    // reset state, then program 0: CMP/branch flag behaviour and HALT
    step("rst0",        0, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("rst1",        0, 1, 9'h1F0, 1, 1, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("idle0",       1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("pulse0",      1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 1, 0, 0, 2'd0);
    step("cmp_z",       1, 1, 9'h080, 1, 0, 5'h08, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("be",          1, 1, 9'h132, 0, 1, 5'h13, 1, 0, 15'h7FFD, 0, 0, 0, 2'd0);
    step("cmp_lt",      1, 0, 9'h080, 0, 1, 5'h08, 1, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("bg",          1, 0, 9'h125, 1, 0, 5'h12, 0, 1, 15'h0008, 0, 0, 0, 2'd0);
    step("alu_op",      1, 0, 9'h01A, 1, 0, 5'h01, 0, 1, 15'h0000, 0, 0, 0, 2'd0);
    step("halt0",       1, 1, 9'h1F0, 1, 0, 5'h1F, 0, 1, 15'h0000, 0, 0, 0, 2'd0);
    step("done0",       1, 1, 9'h000, 0, 0, 5'h00, 0, 1, 15'h0000, 0, 1, 0, 2'd1);
    step("done0_drop",  1, 0, 9'h000, 0, 0, 5'h00, 0, 1, 15'h0000, 0, 1, 0, 2'd1);
    step("idle1",       1, 0, 9'h1F0, 0, 0, 5'h00, 0, 1, 15'h0000, 0, 0, 0, 2'd1);

    // program 1: watchdog expiry after 8 RUN cycles, start dropped mid-run
    step("idle1_start", 1, 1, 9'h000, 0, 0, 5'h00, 0, 1, 15'h0000, 0, 0, 0, 2'd1);
    step("pulse1",      1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 1, 0, 0, 2'd1);
    for (int i = 0; i < 8; i++)
      step("wd_run",    1, 0, 9'h010, 1, 1, 5'h01, 0, 0, 15'h0000, 0, 0, 0, 2'd1);
    step("wd_done",     1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 1, 1, 2'd2);
    step("idle2",       1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd2);

    // program 2: HALT on the last allowed cycle wins over the watchdog
    step("idle2_start", 1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd2);
    step("pulse2",      1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 1, 0, 0, 2'd2);
    for (int i = 0; i < 7; i++)
      step("run2",      1, 1, 9'h010, 0, 0, 5'h01, 0, 0, 15'h0000, 0, 0, 0, 2'd2);
    step("halt_lim",    1, 1, 9'h1F0, 0, 0, 5'h1F, 0, 0, 15'h0000, 0, 0, 0, 2'd2);
    step("done2",       1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 1, 0, 2'd3);
    step("done2_drop",  1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 1, 0, 2'd3);
    step("idle3",       1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd3);
    for (int i = 0; i < 3; i++)
      step("no_4th",    1, 1, 9'h1F0, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd3);

    // reset clears prog_idx; then asynchronous reset in the middle of RUN
    step("rst_idx",     0, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("idle4_start", 1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("pulse4",      1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 1, 0, 0, 2'd0);
    step("run4_cmp",    1, 1, 9'h080, 1, 0, 5'h08, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("run4_ba",     1, 1, 9'h103, 0, 0, 5'h10, 1, 0, 15'h0004, 0, 0, 0, 2'd0);
    step("async_rst",   0, 1, 9'h103, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("post_start",  1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("post_pulse",  1, 1, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 1, 0, 0, 2'd0);
    step("post_halt",   1, 1, 9'h1F0, 0, 0, 5'h1F, 0, 0, 15'h0000, 0, 0, 0, 2'd0);
    step("post_done",   1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 1, 0, 2'd1);
    step("post_idle",   1, 0, 9'h000, 0, 0, 5'h00, 0, 0, 15'h0000, 0, 0, 0, 2'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left in scoreboard, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
